// File: rtl/fp_seq_subtractor.sv
// -----------------------------------------------------------------------------
// fp_seq_subtractor
//   Multi-cycle subtractor, result = a - b, on fp_pkg::float operands.
//   The subtrahend is negated and the pair is then handled as an addition:
//   operands are sorted by magnitude, the small mantissa is aligned one bit
//   per cycle, added or subtracted, and the sum is normalised one bit per
//   cycle. All arithmetic truncates (no guard/round/sticky bits).
//
// Ports
//   clk        in   clock, rising edge
//   rst_n      in   asynchronous active-low reset
//   in_valid   in   a/b hold a valid operand pair
//   in_ready   out  idle, operands are accepted this cycle if in_valid
//   a          in   minuend
//   b          in   subtrahend
//   out_valid  out  result is valid (held until out_ready)
//   out_ready  in   consumer takes the result
//   result     out  registered difference
// -----------------------------------------------------------------------------
package fp_pkg;
   localparam int EXPONENT_BITS = 8;
   localparam int FRACTION_BITS = 23;

   typedef struct packed {
      logic                     sign;
      logic [EXPONENT_BITS-1:0] exp;
      logic [FRACTION_BITS-1:0] frac;
   } float;
endpackage

module fp_seq_subtractor
   import fp_pkg::*;
(
   input  logic clk,
   input  logic rst_n,
   input  logic in_valid,
   output logic in_ready,
   input  float a,
   input  float b,
   output logic out_valid,
   input  logic out_ready,
   output float result
);

   localparam int EW = EXPONENT_BITS;
   localparam int FW = FRACTION_BITS;
   localparam int LIM = FW + 2;
   localparam logic [EW-1:0] LIM_E = EW'(LIM);
   localparam logic [EW-1:0] ONE_E = EW'(1);

   typedef enum logic [2:0] {S_IDLE, S_ALIGN, S_ADD, S_NORM, S_DONE} state_t;

   state_t          r_state;
   state_t          w_state_next;

   logic            r_sign_big;    // doubles as the result sign after ADD
   logic            r_sign_small;
   logic            r_zero_sign;   // sign used when tmp == 0 (only set for 0 - 0)
   logic [EW-1:0]   r_exp;         // big exponent, then result exponent
   logic [EW-1:0]   r_diff;
   logic [FW:0]     r_mant_big;
   logic [FW:0]     r_mant_small;
   logic [FW+1:0]   r_tmp;

   float            w_b_neg;
   float            w_big;
   float            w_small;
   logic            w_a_big;
   logic            w_accept;
   logic            w_both_zero;
   logic [FW+1:0]   w_sum;
   logic [FW+1:0]   w_tmp_sh;
   logic [EW-1:0]   w_exp_dec;

   assign w_accept    = in_valid && in_ready;
   assign w_b_neg     = {~b.sign, b.exp, b.frac};
   // Tie on magnitude keeps a as the big operand.
   assign w_a_big     = {a.exp, a.frac} >= {b.exp, b.frac};
   assign w_big       = w_a_big ? a : w_b_neg;
   assign w_small     = w_a_big ? w_b_neg : a;
   assign w_both_zero = ({a.exp, a.frac} == '0) && ({b.exp, b.frac} == '0);

   // Big magnitude >= small magnitude, so the difference never goes negative.
   assign w_sum = (r_sign_big == r_sign_small)
                  ? ({1'b0, r_mant_big} + {1'b0, r_mant_small})
                  : ({1'b0, r_mant_big} - {1'b0, r_mant_small});

   assign w_tmp_sh  = r_tmp << 1;
   assign w_exp_dec = r_exp - ONE_E;

   assign result = {r_sign_big, r_exp, r_tmp[FW-1:0]};

   // State register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_state_next;
      end
   end

   // Next-state and handshake flags
   always_comb begin
      w_state_next = r_state;
      in_ready     = 1'b0;
      out_valid    = 1'b0;
      case (r_state)
         S_IDLE: begin
            in_ready = 1'b1;
            if (w_accept) w_state_next = S_ALIGN;
         end
         S_ALIGN: begin
            if (r_diff >= LIM_E || r_diff <= ONE_E) w_state_next = S_ADD;
         end
         S_ADD: begin
            if (w_sum == '0 || w_sum[FW+1] || w_sum[FW] || r_exp == '0)
               w_state_next = S_DONE;
            else
               w_state_next = S_NORM;
         end
         S_NORM: begin
            // Decision is taken on the values this shift produces.
            if (w_tmp_sh[FW] || w_exp_dec == '0) w_state_next = S_DONE;
         end
         S_DONE: begin
            out_valid = 1'b1;
            if (out_ready) w_state_next = S_IDLE;
         end
         default: w_state_next = S_IDLE;
      endcase
   end

   // Datapath
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_sign_big   <= 1'b0;
         r_sign_small <= 1'b0;
         r_zero_sign  <= 1'b0;
         r_exp        <= '0;
         r_diff       <= '0;
         r_mant_big   <= '0;
         r_mant_small <= '0;
         r_tmp        <= '0;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (w_accept) begin
                  r_sign_big   <= w_big.sign;
                  r_sign_small <= w_small.sign;
                  r_zero_sign  <= w_both_zero & a.sign & ~b.sign;
                  r_exp        <= w_big.exp;
                  r_diff       <= w_big.exp - w_small.exp;
                  r_mant_big   <= {|w_big.exp, w_big.frac};
                  r_mant_small <= {|w_small.exp, w_small.frac};
               end
            end
            S_ALIGN: begin
               if (r_diff >= LIM_E) begin
                  r_mant_small <= '0;
               end else if (r_diff <= ONE_E) begin
                  r_mant_small <= r_mant_small >> r_diff[0];
               end else begin
                  r_mant_small <= r_mant_small >> 1;
                  r_diff       <= r_diff - ONE_E;
               end
            end
            S_ADD: begin
               if (w_sum == '0) begin
                  r_sign_big <= r_zero_sign;
                  r_exp      <= '0;
                  r_tmp      <= '0;
               end else if (w_sum[FW+1]) begin
                  r_tmp <= w_sum >> 1;
                  r_exp <= r_exp + ONE_E;
               end else begin
                  r_tmp <= w_sum;
               end
            end
            S_NORM: begin
               r_tmp <= w_tmp_sh;
               r_exp <= w_exp_dec;
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_fp_seq_subtractor.sv
module tb_fp_seq_subtractor;
   import fp_pkg::*;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   logic in_valid = 1'b0;
   logic out_ready = 1'b0;
   logic in_ready;
   logic out_valid;
   float a_i = '0;
   float b_i = '0;
   float result;

   int checks = 0;
   int errors = 0;

   fp_seq_subtractor dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .a         (a_i),
      .b         (b_i),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .result    (result)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      checks++;
      assert (obs === expv) else begin
         errors++;
         $error("FAIL %s: observed %h expected %h", tag, obs, expv);
      end
   endtask

   // Reference: a - b computed as whole-number mantissa arithmetic.
   task automatic ref_model(input logic [31:0] ta, input logic [31:0] tb_,
                            output logic [31:0] res, output int lat);
      logic [31:0] bn, big, sml;
      int eb, es, d, mb, ms, t, na, nn;
      logic [7:0] e;
      logic s;
      bn = {~tb_[31], tb_[30:0]};
      if (ta[30:0] >= bn[30:0]) begin big = ta; sml = bn; end
      else begin big = bn; sml = ta; end
      eb = int'(big[30:23]);
      es = int'(sml[30:23]);
      mb = int'({(eb != 0), big[22:0]});
      ms = int'({(es != 0), sml[22:0]});
      d  = eb - es;
      na = (d <= 1 || d >= 25) ? 1 : d;
      ms = (d >= 25) ? 0 : (ms >> d);
      t  = (big[31] == sml[31]) ? (mb + ms) : (mb - ms);
      e  = big[30:23];
      s  = big[31];
      nn = 0;
      if (t == 0) begin
         e = 8'd0;
         s = (ta[30:0] == 31'd0 && tb_[30:0] == 31'd0) ? (ta[31] & ~tb_[31]) : 1'b0;
      end else if (t >= (1 << 24)) begin
         t = t >> 1;
         e = e + 8'd1;
      end else begin
         while (t < (1 << 23) && e != 8'd0) begin
            t = t << 1;
            e = e - 8'd1;
            nn++;
         end
      end
      res = {s, e, t[22:0]};
      lat = na + 1 + nn;
   endtask

   // One transaction: accept, measure latency, check result, optional hold.
   task automatic do_op(input string tag, input logic [31:0] ta, input logic [31:0] tb_,
                        input logic [31:0] eres, input int elat, input int hold);
      int cyc;
      logic [31:0] held;
      @(negedge clk);
      check({tag, ".idle_ready"}, in_ready, 1);
      a_i = ta;
      b_i = tb_;
      in_valid = 1'b1;
      out_ready = 1'b0;
      @(posedge clk); #1;
      in_valid = 1'b0;
      a_i = $urandom;
      b_i = $urandom;
      check({tag, ".busy"}, in_ready, 0);
      cyc = 0;
      while (out_valid !== 1'b1 && cyc < 100) begin
         @(posedge clk); #1;
         cyc++;
      end
      check({tag, ".latency"}, cyc, elat);
      check({tag, ".result"}, result, eres);
      held = result;
      for (int i = 0; i < hold; i++) begin
         if (i == 1) begin
            a_i = 32'h3F800000;
            b_i = 32'h40400000;
            in_valid = 1'b1;
         end else begin
            in_valid = 1'b0;
         end
         @(posedge clk); #1;
         check({tag, ".hold_result"}, result, held);
         check({tag, ".hold_valid"}, out_valid, 1);
         check({tag, ".hold_ready"}, in_ready, 0);
      end
      in_valid = 1'b0;
      out_ready = 1'b1;
      @(posedge clk); #1;
      out_ready = 1'b0;
      check({tag, ".exit_valid"}, out_valid, 0);
      check({tag, ".exit_ready"}, in_ready, 1);
   endtask

   initial begin
      logic [31:0] ra, rb, rres;
      int rlat;

      // Reset while asserted, before and after release
      #2;
      check("rst_in_ready", in_ready, 1);
      check("rst_out_valid", out_valid, 0);
      check("rst_result", result, 0);
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk); #1;
      check("post_rst_in_ready", in_ready, 1);
      check("post_rst_out_valid", out_valid, 0);
      check("post_rst_result", result, 0);

      // Directed cases
      do_op("basic",     32'h40400000, 32'h3F800000, 32'h40000000, 2, 5);
      do_op("carry",     32'h3F800000, 32'hBF800000, 32'h40000000, 2, 0);
      do_op("cancel",    32'h3F800000, 32'h3F800000, 32'h00000000, 2, 0);
      do_op("negzero",   32'h80000000, 32'h00000000, 32'h80000000, 2, 0);
      do_op("poszero",   32'h00000000, 32'h00000000, 32'h00000000, 2, 0);
      do_op("deepnorm",  32'h3F800000, 32'h3F7FFFFF, 32'h34000000, 25, 0);
      do_op("align24",   32'h4B800000, 32'h3F800000, 32'h4B800000, 25, 0);
      do_op("flush",     32'h4E800000, 32'h3F800000, 32'h4E800000, 2, 2);

      // Reset in the middle of NORM
      @(negedge clk);
      a_i = 32'h3F800000;
      b_i = 32'h3F7FFFFF;
      in_valid = 1'b1;
      @(posedge clk); #1;
      in_valid = 1'b0;
      repeat (6) @(posedge clk);
      #2;
      check("norm_busy", in_ready, 0);
      #1;
      rst_n = 1'b0;
      #1;
      check("midrst_out_valid", out_valid, 0);
      check("midrst_in_ready", in_ready, 1);
      check("midrst_result", result, 0);
      @(negedge clk);
      rst_n = 1'b1;
      do_op("after_rst", 32'h40400000, 32'h3F800000, 32'h40000000, 2, 0);

      // Randomised operands against the reference model
      for (int i = 0; i < 40; i++) begin
         ra = $urandom;
         rb = $urandom;
         case (i % 4)
            1: rb[30:23] = ra[30:23] + 8'($urandom_range(0, 2));
            2: rb[30:0]  = ra[30:0] ^ 31'($urandom_range(0, 255));
            3: begin
               ra[30:23] = 8'($urandom_range(0, 2));
               rb[30:23] = 8'($urandom_range(0, 2));
            end
            default: ;
         endcase
         ref_model(ra, rb, rres, rlat);
         do_op($sformatf("rand%0d", i), ra, rb, rres, rlat, (i % 7 == 0) ? 3 : 0);
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
